// File: rtl/spm_ecc_err_log.sv
// Multi-channel ECC error logger: UE-first/lowest-channel selection, FWFT log FIFO, saturating counters.
// Optional per-entry push timestamp enabled by defining SPM_ECC_ERR_LOG_TIMESTAMP_EN.
module spm_ecc_err_log #(
    parameter int NumCh  = 4,
    parameter int Depth  = 4,
    parameter int IndexW = 16,
    parameter int SyndW  = 8,
    parameter int CntW   = 16,
`ifdef SPM_ECC_ERR_LOG_TIMESTAMP_EN
    parameter int TsW    = 32,
`endif
    localparam int ChW   = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NumCh-1:0]        i_err_valid,
    input  logic [NumCh-1:0]        i_err_ue,
    input  logic [NumCh*IndexW-1:0] i_err_index,
    input  logic [NumCh*SyndW-1:0]  i_err_syndrome,
    input  logic                    i_disable,
    input  logic                    i_clear,
    input  logic                    i_irq_en,
    output logic                    o_log_valid,
    input  logic                    i_log_ready,
    output logic [ChW-1:0]          o_log_ch,
    output logic                    o_log_ue,
    output logic [IndexW-1:0]       o_log_index,
    output logic [SyndW-1:0]        o_log_syndrome,
    output logic [CntW-1:0]         o_ce_cnt,
    output logic [CntW-1:0]         o_ue_cnt,
    output logic [CntW-1:0]         o_drop_cnt,
    output logic                    o_overflow,
`ifdef SPM_ECC_ERR_LOG_TIMESTAMP_EN
    output logic [TsW-1:0]          o_log_ts,
`endif
    output logic                    o_irq
);

    localparam int PtrW  = $clog2(Depth);
    localparam int FcntW = $clog2(Depth + 1);
    localparam int PopW  = $clog2(NumCh + 1);
    localparam int SumW  = ((CntW > PopW) ? CntW : PopW) + 1;
    localparam logic [CntW-1:0] CntMax = '1;

    typedef struct packed {
        logic [ChW-1:0]    ch;
        logic              ue;
        logic [IndexW-1:0] index;
        logic [SyndW-1:0]  syndrome;
`ifdef SPM_ECC_ERR_LOG_TIMESTAMP_EN
        logic [TsW-1:0]    ts;
`endif
    } entry_t;

    function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a, input logic [PopW-1:0] b);
        logic [SumW-1:0] sum;
        sum = SumW'(a) + SumW'(b);
        return (sum > SumW'(CntMax)) ? CntMax : sum[CntW-1:0];
    endfunction

    // Selection and per-class popcounts
    logic [NumCh-1:0] qual, qual_ue, qual_ce;
    logic             sel_valid;
    logic [ChW-1:0]   sel_ch;
    logic [PopW-1:0]  ce_pop, ue_pop;
    entry_t           new_entry;

    // NOTE: blocking assignments in combinational logic; the descending loops let the
    // lowest qualified channel overwrite higher ones, and the UE loop runs last so it wins.
    always_comb begin
        qual      = i_err_valid & ~{NumCh{i_disable}};
        qual_ue   = qual & i_err_ue;
        qual_ce   = qual & ~i_err_ue;
        sel_valid = |qual;
        sel_ch    = '0;
        ce_pop    = '0;
        ue_pop    = '0;
        for (int c = NumCh - 1; c >= 0; c--) begin
            if (qual_ce[c]) sel_ch = ChW'(c);
        end
        for (int c = NumCh - 1; c >= 0; c--) begin
            if (qual_ue[c]) sel_ch = ChW'(c);
        end
        for (int c = 0; c < NumCh; c++) begin
            ce_pop = ce_pop + PopW'(qual_ce[c]);
            ue_pop = ue_pop + PopW'(qual_ue[c]);
        end
    end

    logic [`ifdef SPM_ECC_ERR_LOG_TIMESTAMP_EN TsW `else 1 `endif -1:0] ts_unused_q;

    always_comb begin
        new_entry          = '0;
        new_entry.ch       = sel_ch;
        new_entry.ue       = |qual_ue;
        new_entry.index    = i_err_index[int'(sel_ch) * IndexW +: IndexW];
        new_entry.syndrome = i_err_syndrome[int'(sel_ch) * SyndW +: SyndW];
`ifdef SPM_ECC_ERR_LOG_TIMESTAMP_EN
        new_entry.ts       = ts_unused_q;
`endif
    end

    // FIFO state, registered head and status
    entry_t          mem_q [Depth];
    entry_t          head_q, head_d;
    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [FcntW-1:0] count_q, count_d, remain;
    logic            valid_q, valid_d;
    logic [CntW-1:0] ce_q, ce_d, ue_q, ue_d, drop_q, drop_d;
    logic            ovf_q, ovf_d, irq_q, irq_d;
    logic            pop, push;
    logic [PopW-1:0] drop_n;

    assign pop    = valid_q & i_log_ready;
    assign push   = sel_valid & ((count_q != FcntW'(Depth)) | pop);
    assign drop_n = ce_pop + ue_pop - PopW'(push);

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        head_d  = head_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        valid_d = valid_q;
        ce_d    = ce_q;
        ue_d    = ue_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        remain  = count_q - FcntW'(pop);
        irq_d   = i_irq_en & (valid_q | ovf_q);
        if (i_clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            valid_d = 1'b0;
            ce_d    = '0;
            ue_d    = '0;
            drop_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            rd_d    = rd_q + PtrW'(pop);
            wr_d    = wr_q + PtrW'(push);
            count_d = count_q + FcntW'(push) - FcntW'(pop);
            valid_d = (count_d != '0);
            // New head is an older stored entry if any remain, else the entry pushed now
            if (remain != '0) begin
                head_d = mem_q[rd_d];
            end else if (push) begin
                head_d = new_entry;
            end
            ce_d   = sat_add(ce_q, ce_pop);
            ue_d   = sat_add(ue_q, ue_pop);
            drop_d = sat_add(drop_q, drop_n);
            ovf_d  = ovf_q | (drop_n != '0);
        end
    end

    // NOTE: storage has no reset; only entries covered by count_q are ever read.
    always_ff @(posedge i_clk) begin
        if (push && !i_clear) mem_q[wr_q] <= new_entry;
    end

    // NOTE: non-blocking assignments for all sequential state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ce_q    <= '0;
            ue_q    <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ce_q    <= ce_d;
            ue_q    <= ue_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

`ifdef SPM_ECC_ERR_LOG_TIMESTAMP_EN
    // Free-running cycle counter; deliberately untouched by i_clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ts_unused_q <= '0;
        else          ts_unused_q <= ts_unused_q + 1'b1;
    end
    assign o_log_ts = head_q.ts;
`else
    assign ts_unused_q = 1'b0;
`endif

    assign o_log_valid    = valid_q;
    assign o_log_ch       = head_q.ch;
    assign o_log_ue       = head_q.ue;
    assign o_log_index    = head_q.index;
    assign o_log_syndrome = head_q.syndrome;
    assign o_ce_cnt       = ce_q;
    assign o_ue_cnt       = ue_q;
    assign o_drop_cnt     = drop_q;
    assign o_overflow     = ovf_q;
    assign o_irq          = irq_q;

endmodule

// File: tb/tb_spm_ecc_err_log.sv
// Self-checking bench for spm_ecc_err_log: directed test-plan steps then randomized traffic
// compared against a queue-based reference model. Built with CntW=4 to reach saturation.
module tb_spm_ecc_err_log;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int SAT   = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  err_valid, err_ue;
    logic [63:0] err_index;
    logic [31:0] err_syn;
    logic        dis, clr, irq_en, ready;
    logic        log_valid, log_ue, overflow, irq;
    logic [1:0]  log_ch;
    logic [15:0] log_index;
    logic [7:0]  log_syn;
    logic [3:0]  ce_cnt, ue_cnt, drop_cnt;
`ifdef SPM_ECC_ERR_LOG_TIMESTAMP_EN
    logic [31:0] log_ts;
`endif

    spm_ecc_err_log #(.NumCh(NCH), .Depth(DEPTH), .IndexW(16), .SyndW(8), .CntW(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_err_valid(err_valid), .i_err_ue(err_ue),
        .i_err_index(err_index), .i_err_syndrome(err_syn),
        .i_disable(dis), .i_clear(clr), .i_irq_en(irq_en),
        .o_log_valid(log_valid), .i_log_ready(ready),
        .o_log_ch(log_ch), .o_log_ue(log_ue),
        .o_log_index(log_index), .o_log_syndrome(log_syn),
        .o_ce_cnt(ce_cnt), .o_ue_cnt(ue_cnt), .o_drop_cnt(drop_cnt),
        .o_overflow(overflow),
`ifdef SPM_ECC_ERR_LOG_TIMESTAMP_EN
        .o_log_ts(log_ts),
`endif
        .o_irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: list of logged entries plus plain integer counters
    typedef struct { int ch; bit ue; int idx; int syn; } ent_t;
    ent_t q_m[$];
    int   ce_m, ue_m, drop_m;
    bit   ovf_m, irq_m;

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic model_reset();
        q_m.delete();
        ce_m = 0; ue_m = 0; drop_m = 0; ovf_m = 0; irq_m = 0;
    endtask

    task automatic model_step();
        int   nce, nue, sel, unlogged;
        ent_t e;
        irq_m = irq_en && (q_m.size() != 0 || ovf_m);
        if (clr) begin
            q_m.delete();
            ce_m = 0; ue_m = 0; drop_m = 0; ovf_m = 0;
            return;
        end
        nce = 0; nue = 0; sel = -1;
        if (!dis) begin
            for (int c = 0; c < NCH; c++) begin
                if (err_valid[c]) begin
                    if (err_ue[c]) nue++; else nce++;
                    if (err_ue[c] && sel < 0) sel = c;
                end
            end
            for (int c = 0; c < NCH; c++)
                if (err_valid[c] && sel < 0) sel = c;
        end
        if (q_m.size() != 0 && ready) void'(q_m.pop_front());
        unlogged = nce + nue;
        if (sel >= 0 && q_m.size() < DEPTH) begin
            e.ch  = sel;
            e.ue  = err_ue[sel];
            e.idx = int'(err_index[sel*16 +: 16]);
            e.syn = int'(err_syn[sel*8 +: 8]);
            q_m.push_back(e);
            unlogged--;
        end
        ce_m   = sat(ce_m + nce);
        ue_m   = sat(ue_m + nue);
        drop_m = sat(drop_m + unlogged);
        if (unlogged > 0) ovf_m = 1;
    endtask

    task automatic check_all();
        chk("log_valid", 32'(log_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0) begin
            chk("log_ch", 32'(log_ch), q_m[0].ch);
            chk("log_ue", 32'(log_ue), 32'(q_m[0].ue));
            chk("log_index", 32'(log_index), q_m[0].idx);
            chk("log_syndrome", 32'(log_syn), q_m[0].syn);
        end
        chk("ce_cnt", 32'(ce_cnt), ce_m);
        chk("ue_cnt", 32'(ue_cnt), ue_m);
        chk("drop_cnt", 32'(drop_cnt), drop_m);
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("irq", 32'(irq), 32'(irq_m));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(log_valid), 0);
        chk({tag, "_ch"}, 32'(log_ch), 0);
        chk({tag, "_ue"}, 32'(log_ue), 0);
        chk({tag, "_index"}, 32'(log_index), 0);
        chk({tag, "_syndrome"}, 32'(log_syn), 0);
        chk({tag, "_ce"}, 32'(ce_cnt), 0);
        chk({tag, "_uecnt"}, 32'(ue_cnt), 0);
        chk({tag, "_drop"}, 32'(drop_cnt), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_irq"}, 32'(irq), 0);
    endtask

    // Inputs are set between edges; the model advances, then outputs are sampled #1 after the edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        err_valid = '0; err_ue = '0; clr = 0; dis = 0;
    endtask

    task automatic ev(input int ch, input bit ue, input logic [15:0] idx, input logic [7:0] syn);
        err_valid[ch]        = 1'b1;
        err_ue[ch]           = ue;
        err_index[ch*16 +: 16] = idx;
        err_syn[ch*8 +: 8]     = syn;
    endtask

    task automatic do_clear();
        idle(); clr = 1; cycle(); clr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_pct;
        rst_n = 0; err_index = '0; err_syn = '0; irq_en = 1; ready = 0;
        idle();
        model_reset();
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;

        // 1: single CE event on ch2, irq one cycle after valid
        ev(2, 0, 16'h0123, 8'h5A); cycle();
        chk("t1_valid", 32'(log_valid), 1);
        chk("t1_ch", 32'(log_ch), 2);
        chk("t1_index", 32'(log_index), 32'h0123);
        chk("t1_syndrome", 32'(log_syn), 32'h5A);
        chk("t1_ce", 32'(ce_cnt), 1);
        chk("t1_irq_lag", 32'(irq), 0);
        idle(); cycle();
        chk("t1_irq", 32'(irq), 1);

        // 2: simultaneous CE ch0 and UE ch3, UE wins
        do_clear();
        ev(0, 0, 16'h1111, 8'h11); ev(3, 1, 16'h3333, 8'h33); cycle();
        chk("t2_ch", 32'(log_ch), 3);
        chk("t2_ue", 32'(log_ue), 1);
        chk("t2_uecnt", 32'(ue_cnt), 1);
        chk("t2_ce", 32'(ce_cnt), 1);
        chk("t2_drop", 32'(drop_cnt), 1);
        chk("t2_ovf", 32'(overflow), 1);

        // 3: fill FIFO, one drop; then push with pop at full is accepted
        idle(); do_clear();
        for (int i = 0; i < 5; i++) begin
            idle(); ev(1, 0, 16'(16'h0100 + i), 8'(i)); cycle();
        end
        chk("t3_drop", 32'(drop_cnt), 1);
        idle(); ev(1, 0, 16'h0200, 8'h77); ready = 1; cycle();
        chk("t3_drop_pop", 32'(drop_cnt), 1);
        chk("t3_ce", 32'(ce_cnt), 6);
        idle(); ready = 0;

        // 4: UE counter saturates at 15
        do_clear(); ready = 1;
        for (int i = 0; i < 17; i++) begin
            idle(); ev(0, 1, 16'(i), 8'(i)); cycle();
        end
        chk("t4_ue_sat", 32'(ue_cnt), 15);
        idle(); ready = 0;

        // 5: clear beats same-cycle event
        do_clear();
        ev(0, 0, 16'hA0, 8'h0A); cycle(); idle();
        ev(2, 1, 16'hA2, 8'h2A); cycle(); idle();
        cycle();
        clr = 1; ev(1, 1, 16'hA1, 8'h1A); cycle(); idle();
        chk("t5_valid", 32'(log_valid), 0);
        chk("t5_uecnt", 32'(ue_cnt), 0);
        chk("t5_ovf", 32'(overflow), 0);
        chk("t5_irq_lag", 32'(irq), 1);
        cycle();
        chk("t5_irq", 32'(irq), 0);

        // 6: disable keeps counters, FIFO drains; then async reset mid-burst
        ev(1, 0, 16'hB1, 8'hB1); cycle(); idle();
        ev(2, 0, 16'hB2, 8'hB2); cycle(); idle();
        dis = 1; ready = 1;
        for (int c = 0; c < NCH; c++) ev(c, c[0], 16'(c), 8'(c));
        cycle();
        chk("t6_ce_hold", 32'(ce_cnt), 2);
        chk("t6_valid1", 32'(log_valid), 1);
        cycle();
        chk("t6_valid0", 32'(log_valid), 0);
        idle(); ready = 0;
        for (int i = 0; i < 3; i++) begin
            idle(); ev(i, i[0], 16'(16'hC0 + i), 8'(i)); ev(3, 0, 16'hCC, 8'hCC); cycle();
        end
        #2; rst_n = 0; #1;
        check_reset_values("midrst");
        model_reset(); idle();
        @(negedge clk); rst_n = 1;

        // Randomized traffic
        rdy_pct = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) rdy_pct = $urandom_range(0, 100);
            err_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            err_ue    = 4'($urandom_range(0, 15));
            err_index = {$urandom(), $urandom()};
            err_syn   = $urandom();
            dis       = ($urandom_range(0, 15) == 0);
            clr       = ($urandom_range(0, 63) == 0);
            irq_en    = ($urandom_range(0, 7) != 0);
            ready     = ($urandom_range(0, 99) < rdy_pct);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
